// File: rtl/button_conditioner_if.sv
// Raw button inputs and conditioned press-event outputs for one stopwatch keypad.
// The master side drives the raw buttons. The slave side is the conditioner.
interface button_conditioner_if;
  logic       btn_start_raw;
  logic       btn_stop_raw;
  logic       btn_reset_raw;
  logic       start_pulse;
  logic       stop_pulse;
  logic       reset_pulse;
  logic [2:0] btn_level;
  logic       collision;

  modport master (
    output btn_start_raw, btn_stop_raw, btn_reset_raw,
    input  start_pulse, stop_pulse, reset_pulse, btn_level, collision
  );

  modport slave (
    input  btn_start_raw, btn_stop_raw, btn_reset_raw,
    output start_pulse, stop_pulse, reset_pulse, btn_level, collision
  );
endinterface

// File: rtl/button_conditioner.sv
// Three-channel button conditioner: synchronize, debounce and edge-detect each button.
// Coincident presses are arbitrated so that reset beats stop, and stop beats start.
module button_conditioner #(
    parameter int unsigned DB_CYCLES = 500000,
    parameter int unsigned CNT_W     = 19
) (
    input  logic                 clk,
    input  logic                 rst_n,
    button_conditioner_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [2:0] w_raw;
    logic [2:0] w_stable;
    logic [2:0] w_rise;
    logic [2:0] r_stable_d;
    logic       r_start_pulse;
    logic       r_stop_pulse;
    logic       r_reset_pulse;
    logic       r_collision;

    assign w_raw = {bus.btn_reset_raw, bus.btn_stop_raw, bus.btn_start_raw};

    for (genvar ch = 0; ch < 3; ch++) begin : g_chan
        logic             r_sync1;
        logic             r_sync2;
        logic             r_stable;
        logic [CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_stable <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_sync1 <= w_raw[ch];
                r_sync2 <= r_sync1;
                // Any sample matching the stable level restarts the window.
                if (r_sync2 == r_stable) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_MAX) begin
                    r_stable <= ~r_stable;
                    r_cnt    <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
            end
        end

        assign w_stable[ch] = r_stable;
    end

    assign w_rise = w_stable & ~r_stable_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable_d    <= '0;
            r_start_pulse <= 1'b0;
            r_stop_pulse  <= 1'b0;
            r_reset_pulse <= 1'b0;
            r_collision   <= 1'b0;
        end else begin
            r_stable_d    <= w_stable;
            r_reset_pulse <= w_rise[2];
            r_stop_pulse  <= w_rise[1] & ~w_rise[2];
            r_start_pulse <= w_rise[0] & ~(|w_rise[2:1]);
            r_collision   <= (w_rise[0] & w_rise[1]) |
                             (w_rise[0] & w_rise[2]) |
                             (w_rise[1] & w_rise[2]);
        end
    end

    assign bus.start_pulse = r_start_pulse;
    assign bus.stop_pulse  = r_stop_pulse;
    assign bus.reset_pulse = r_reset_pulse;
    assign bus.collision   = r_collision;
    assign bus.btn_level   = w_stable;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4: per-cycle vector table
// plus hand-written bounce and reset sequences.
module tb_button_conditioner;

    typedef struct {
        logic [2:0] raw;    // {reset, stop, start}
        logic [2:0] pulse;  // {reset_pulse, stop_pulse, start_pulse}
        logic [2:0] level;
        logic       col;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    bit   invariant_on;
    vec_t vecs[$];

    button_conditioner_if bif ();

    button_conditioner #(
        .DB_CYCLES (4),
        .CNT_W     (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] pulses();
        return {bif.reset_pulse, bif.stop_pulse, bif.start_pulse};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h want %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r);
        bif.btn_reset_raw = r[2];
        bif.btn_stop_raw  = r[1];
        bif.btn_start_raw = r[0];
    endtask

    task automatic step(input logic [2:0] r);
        @(negedge clk);
        drive(r);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [2:0] r, input logic [2:0] p, input logic [2:0] l,
                       input logic c);
        vec_t v;
        v.raw = r; v.pulse = p; v.level = l; v.col = c;
        vecs.push_back(v);
    endtask

    task automatic chk_all_zero(input string name, input int idx);
        chk(name, idx, {28'd0, pulses(), bif.collision}, 32'd0);
        chk({name, "_lvl"}, idx, {29'd0, bif.btn_level}, 32'd0);
    endtask

    // At most one press pulse in any cycle.
    always @(negedge clk) begin
        if (invariant_on) begin
            chk("onehot", 0, {31'd0, (32'(bif.start_pulse) + 32'(bif.stop_pulse) +
                                      32'(bif.reset_pulse)) > 32'd1}, 32'd0);
        end
    end

    initial begin
        int n_p;
        int at_e;
        total        = 0;
        bad          = 0;
        invariant_on = 1'b0;
        rst_n        = 1'b0;
        drive(3'b000);

        // Clean start press, held 50 cycles
        for (int i = 1; i <= 50; i++)
            add(3'b001, (i == 7) ? 3'b001 : 3'b000, (i >= 6) ? 3'b001 : 3'b000, 1'b0);
        // 3-cycle release glitch must not flip the level
        for (int i = 1; i <= 3; i++) add(3'b000, 3'b000, 3'b001, 1'b0);
        for (int i = 1; i <= 8; i++) add(3'b001, 3'b000, 3'b001, 1'b0);
        // Real release: level drops, no pulse
        for (int i = 1; i <= 10; i++)
            add(3'b000, 3'b000, (i >= 6) ? 3'b000 : 3'b001, 1'b0);
        // Staggered: stop one cycle after start
        for (int i = 1; i <= 14; i++)
            add((i == 1) ? 3'b001 : 3'b011,
                {1'b0, i == 8, i == 7},
                {1'b0, i >= 7, i >= 6}, 1'b0);
        for (int i = 1; i <= 10; i++)
            add(3'b000, 3'b000, (i >= 6) ? 3'b000 : 3'b011, 1'b0);
        // Start and reset together: reset wins, collision flagged
        for (int i = 1; i <= 14; i++)
            add(3'b101, (i == 7) ? 3'b100 : 3'b000, (i >= 6) ? 3'b101 : 3'b000, i == 7);
        for (int i = 1; i <= 10; i++)
            add(3'b000, 3'b000, (i >= 6) ? 3'b000 : 3'b101, 1'b0);
        // All three together
        for (int i = 1; i <= 12; i++)
            add(3'b111, (i == 7) ? 3'b100 : 3'b000, (i >= 6) ? 3'b111 : 3'b000, i == 7);
        for (int i = 1; i <= 10; i++)
            add(3'b000, 3'b000, (i >= 6) ? 3'b000 : 3'b111, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_state", 0);
        @(negedge clk);
        rst_n        = 1'b1;
        invariant_on = 1'b1;

        foreach (vecs[k]) begin
            step(vecs[k].raw);
            chk("pulse", k, {29'd0, pulses()}, {29'd0, vecs[k].pulse});
            chk("level", k, {29'd0, bif.btn_level}, {29'd0, vecs[k].level});
            chk("collision", k, {31'd0, bif.collision}, {31'd0, vecs[k].col});
        end

        // Bounce on stop: high 3 / low 1, five times, then held high from edge 21
        n_p = 0; at_e = 0;
        for (int e = 1; e <= 40; e++) begin
            step((e > 20 || (e % 4) != 0) ? 3'b010 : 3'b000);
            if (bif.stop_pulse) begin n_p++; at_e = e; end
            if (bif.start_pulse || bif.reset_pulse || bif.collision) n_p += 100;
        end
        chk("bounce_count", 0, n_p, 1);
        chk("bounce_edge", 0, at_e, 27);
        chk("bounce_level", 0, {29'd0, bif.btn_level}, 32'd2);
        for (int e = 1; e <= 10; e++) step(3'b000);
        chk("bounce_release", 0, {29'd0, bif.btn_level}, 32'd0);

        // Reset raw high 5 cycles, rst_n pulsed at cycle 4: nothing may emerge
        n_p = 0;
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            drive((e <= 5) ? 3'b100 : 3'b000);
            if (e == 4) rst_n = 1'b0;
            if (e == 5) rst_n = 1'b1;
            @(posedge clk);
            #1;
            if (e == 4) chk_all_zero("in_reset", e);
            if (|pulses() || bif.collision) n_p++;
        end
        chk("partial_discard", 0, n_p, 0);
        chk("partial_level", 0, {29'd0, bif.btn_level}, 32'd0);

        // Held reset button: press, async reset, fresh debounce after release
        n_p = 0; at_e = 0;
        for (int e = 1; e <= 10; e++) begin
            step(3'b100);
            if (bif.reset_pulse) begin n_p++; at_e = e; end
        end
        chk("held_count", 0, n_p, 1);
        chk("held_edge", 0, at_e, 7);
        chk("held_level", 0, {29'd0, bif.btn_level}, 32'd4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset", 0);
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            chk_all_zero("held_in_reset", e);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_p = 0; at_e = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (bif.reset_pulse) begin n_p++; at_e = e; end
            if (e == 5) chk("relaunch_lvl5", e, {29'd0, bif.btn_level}, 32'd0);
            if (e == 6) chk("relaunch_lvl6", e, {29'd0, bif.btn_level}, 32'd4);
            if (e < 20) @(negedge clk);
        end
        chk("relaunch_count", 0, n_p, 1);
        chk("relaunch_edge", 0, at_e, 7);
        for (int e = 1; e <= 10; e++) step(3'b000);
        chk("final_level", 0, {29'd0, bif.btn_level}, 32'd0);

        invariant_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 500000, meaning consecutive clk cycles a synchronized input must differ from the stable level before the stable level flips (legal range 2..2^CNT_W-1).
REQ-002 SHALL have parameter CNT_W, default 19, meaning debounce counter width per channel.
REQ-003 SHALL have port clk input 1: system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n input 1: reset, asynchronous, active-low.
REQ-005 SHALL have port btn_start_raw input 1: raw start button, active-high, asynchronous to clk, may bounce.
REQ-006 SHALL have port btn_stop_raw input 1: raw stop button, same properties.
REQ-007 SHALL have port btn_reset_raw input 1: raw reset button, same properties.
REQ-008 SHALL have port start_pulse output 1: one-cycle press event, drives stopwatch FSM start.
REQ-009 SHALL have port stop_pulse output 1: one-cycle press event, drives FSM stop.
REQ-010 SHALL have port reset_pulse output 1: one-cycle press event, drives FSM reset_btn.
REQ-011 SHALL have port btn_level output 3: debounced stable levels {reset, stop, start}, bit0 = start.
REQ-012 SHALL have port collision output 1: one-cycle flag, more than one press event in the same cycle.

Function
REQ-013 Each channel SHALL pass its raw input through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-014 Each channel SHALL hold a stable level and a CNT_W-bit counter; when sync2 equals stable, counter SHALL clear to 0.
REQ-015 When sync2 differs from stable and counter < DB_CYCLES-1, counter SHALL increment by 1.
REQ-016 When sync2 differs from stable and counter == DB_CYCLES-1, stable SHALL toggle and counter SHALL clear to 0 on the same edge.
REQ-017 Counter SHALL never wrap; a single matching sample anywhere in the window restarts the count from 0.
REQ-018 A press event SHALL be a 0->1 transition of a channel's stable level; 1->0 transitions SHALL produce no output pulse.
REQ-019 Outputs *_pulse and collision SHALL be registered and asserted in the cycle after the stable level rises.
REQ-020 Latency: raw input rising before edge 1 and held steady SHALL produce its pulse high between edges DB_CYCLES+3 and DB_CYCLES+4.
REQ-021 Each *_pulse SHALL be high for exactly one cycle per press event regardless of hold duration.
REQ-022 At most one of start_pulse, stop_pulse, reset_pulse SHALL be high in any cycle.
REQ-023 Simultaneous press events SHALL be arbitrated with priority reset > stop > start; lower-priority events in that cycle SHALL be discarded, not deferred.
REQ-024 collision SHALL be high in the same cycle as the winning pulse when two or more press events coincided, else low.
REQ-025 btn_level SHALL equal the stable levels directly (no extra register stage beyond the stable flop).
REQ-026 Channels SHALL be fully independent apart from REQ-022..REQ-024.

Reset
REQ-027 On rst_n low, all synchronizer flops, stable levels, counters, *_pulse, collision and btn_level SHALL go to 0 immediately, regardless of clk.
REQ-028 A button held high across reset release SHALL be debounced afresh and SHALL produce one pulse DB_CYCLES+3 edges after reset deassertion.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL emerge from pre-reset activity.

Verification (DB_CYCLES=4)
REQ-030 Clean press: btn_start_raw 0->1 before edge 1, held 50 cycles -> start_pulse high only between edges 7 and 8; btn_level[0]=1 from edge 6; no further pulses.
REQ-031 Bounce: btn_stop_raw toggles high 3 cycles / low 1 cycle x5 then holds high -> exactly one stop_pulse, 7 edges after the final rising edge of the raw input.
REQ-032 Release glitch: start held high (level=1), raw drops low 3 cycles then returns high -> btn_level[0] stays 1, no pulse; later release 10 cycles -> level 0, no pulse.
REQ-033 Simultaneous: start and reset raw rise on the same cycle -> reset_pulse and collision high for one cycle, start_pulse never asserted.
REQ-034 Reset mid-operation: reset raw high for 5 cycles, rst_n pulsed low at cycle 4 -> all outputs 0 during reset; pulse appears 7 edges after rst_n release if raw still high.
REQ-035 Staggered: stop rises 1 cycle after start -> start_pulse then stop_pulse on consecutive cycles, collision never high.
